// File: rtl/vga_pkg.sv
// Shared framebuffer definitions for the display fetch path, the draw writer
// and the framebuffer access arbiter.
//   FB_ADDR_W   : word-address width of the 320x240 framebuffer
//   FB_DATA_W   : pixel word width
//   WAIT_W      : width of the writer starvation counter
//   STALL_W     : width of the display stall statistic
//   arb_state_t : arbiter FSM state (NORMAL / FORCE_WR)
package vga_pkg;

    localparam int FB_ADDR_W = 17;
    localparam int FB_DATA_W = 8;
    localparam int WAIT_W    = 8;
    localparam int STALL_W   = 16;

    typedef enum logic {
        NORMAL   = 1'b0,
        FORCE_WR = 1'b1
    } arb_state_t;

endpackage

// File: rtl/fb_rd_valid_pipe.sv
// Tracks display reads in flight to the framebuffer RAM.
//   i_clk      : system clock
//   i_n_reset  : asynchronous active-low reset; drops every read in flight
//   i_rd_issue : a read command is on the registered RAM command port
//   o_cap_en   : RAM read data for the oldest read is on i_mem_rdata now
//   o_rvalid   : registered strobe, one cycle after o_cap_en
module fb_rd_valid_pipe #(
    parameter int RD_LATENCY = 1
) (
    input  logic i_clk,
    input  logic i_n_reset,
    input  logic i_rd_issue,
    output logic o_cap_en,
    output logic o_rvalid
);

    logic [RD_LATENCY-1:0] stage;

    // NOTE: every clocked assignment is non-blocking so the shift below reads
    // the pre-edge value of each stage regardless of statement order.
    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            stage    <= '0;
            o_rvalid <= 1'b0;
        end else begin
            stage[0] <= i_rd_issue;
            for (int i = 1; i < RD_LATENCY; i++) begin
                stage[i] <= stage[i-1];
            end
            o_rvalid <= stage[RD_LATENCY-1];
        end
    end

    assign o_cap_en = stage[RD_LATENCY-1];

endmodule

// File: rtl/fb_access_arbiter.sv
// Arbitrates one single-port framebuffer RAM between the display fetch path
// (reads) and the draw writer (writes). Display wins in the visible region,
// the writer wins in blanking, and a starvation counter forces one writer
// grant after MAX_WAIT consecutive denied writer cycles.
//   i_clk, i_n_reset        : clock, asynchronous active-low reset
//   i_drawing               : visible-region flag from the VGA timing core
//   i_disp_req/addr         : display read request, held until o_disp_gnt
//   o_disp_gnt              : combinational display grant
//   o_disp_rvalid/rdata     : registered read return
//   i_wr_req/addr/data      : writer request, held until o_wr_gnt
//   o_wr_gnt                : combinational writer grant
//   o_mem_en/we/addr/wdata  : registered RAM command
//   i_mem_rdata             : RAM read data (RD_LATENCY after the command)
//   i_stall_clr             : synchronous clear of o_stall_cnt
//   o_stall_cnt             : saturating count of visible-region display stalls
module fb_access_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W     = FB_ADDR_W,
    parameter int DATA_W     = FB_DATA_W,
    parameter int MAX_WAIT   = 15,
    parameter int RD_LATENCY = 1
) (
    input  logic               i_clk,
    input  logic               i_n_reset,
    input  logic               i_drawing,
    input  logic               i_disp_req,
    input  logic [ADDR_W-1:0]  i_disp_addr,
    output logic               o_disp_gnt,
    output logic               o_disp_rvalid,
    output logic [DATA_W-1:0]  o_disp_rdata,
    input  logic               i_wr_req,
    input  logic [ADDR_W-1:0]  i_wr_addr,
    input  logic [DATA_W-1:0]  i_wr_data,
    output logic               o_wr_gnt,
    output logic               o_mem_en,
    output logic               o_mem_we,
    output logic [ADDR_W-1:0]  o_mem_addr,
    output logic [DATA_W-1:0]  o_mem_wdata,
    input  logic [DATA_W-1:0]  i_mem_rdata,
    input  logic               i_stall_clr,
    output logic [STALL_W-1:0] o_stall_cnt
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    arb_state_t        state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_next;
    logic              disp_stall;
    logic              rd_cap_en;

    // Grant decision. Grants are gated by reset so nothing is accepted
    // while the command register is held clear.
    // NOTE: both grants get a default before any branch, so no path through
    // the block leaves them unassigned and no latch is inferred.
    always_comb begin
        o_disp_gnt = 1'b0;
        o_wr_gnt   = 1'b0;
        if (!i_n_reset) begin
            o_disp_gnt = 1'b0;
            o_wr_gnt   = 1'b0;
        end else if (state == FORCE_WR && i_wr_req) begin
            o_wr_gnt   = 1'b1;
        end else if (i_drawing) begin
            o_disp_gnt = i_disp_req;
            o_wr_gnt   = i_wr_req && !i_disp_req;
        end else begin
            o_wr_gnt   = i_wr_req;
            o_disp_gnt = i_disp_req && !i_wr_req;
        end
    end

    // Starvation tracking. The FSM enters FORCE_WR in the same cycle that
    // wait_cnt is about to reach MAX_WAIT, so the forced grant lands on the
    // cycle immediately after the MAX_WAIT-th denial.
    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;

        if (o_wr_gnt || !i_wr_req) begin
            wait_next = '0;
        end else if (wait_cnt < MAX_WAIT_C) begin
            wait_next = wait_cnt + WAIT_W'(1);
        end

        unique case (state)
            NORMAL: begin
                if (i_wr_req && !o_wr_gnt && wait_cnt >= MAX_WAIT_C - WAIT_W'(1)) begin
                    state_next = FORCE_WR;
                end
            end
            FORCE_WR: begin
                if (o_wr_gnt || !i_wr_req) begin
                    state_next = NORMAL;
                end
            end
            default: state_next = NORMAL;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            state    <= NORMAL;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

    // Registered RAM command. Address and write data hold when idle so the
    // RAM port does not toggle needlessly.
    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            o_mem_en    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else begin
            o_mem_en <= o_disp_gnt || o_wr_gnt;
            o_mem_we <= o_wr_gnt;
            if (o_wr_gnt) begin
                o_mem_addr  <= i_wr_addr;
                o_mem_wdata <= i_wr_data;
            end else if (o_disp_gnt) begin
                o_mem_addr  <= i_disp_addr;
            end
        end
    end

    // Read return: the pipe starts from the registered read command, so the
    // strobe appears RD_LATENCY + 2 cycles after the grant.
    fb_rd_valid_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_valid_pipe (
        .i_clk      (i_clk),
        .i_n_reset  (i_n_reset),
        .i_rd_issue (o_mem_en && !o_mem_we),
        .o_cap_en   (rd_cap_en),
        .o_rvalid   (o_disp_rvalid)
    );

    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            o_disp_rdata <= '0;
        end else if (rd_cap_en) begin
            o_disp_rdata <= i_mem_rdata;
        end
    end

    // Display stall statistic; a clear takes precedence over a count.
    assign disp_stall = i_drawing && i_disp_req && !o_disp_gnt;

    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            o_stall_cnt <= '0;
        end else if (i_stall_clr) begin
            o_stall_cnt <= '0;
        end else if (disp_stall && o_stall_cnt != '1) begin
            o_stall_cnt <= o_stall_cnt + STALL_W'(1);
        end
    end

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Randomised and directed bench for fb_access_arbiter against a
// transaction-level reference model (denial streak, shadow memory, queue of
// expected read returns).
module tb_fb_access_arbiter;

    localparam int ADDR_W   = 17;
    localparam int DATA_W   = 8;
    localparam int MAX_WAIT = 15;
    localparam int RD_LAT   = 1;
    localparam int WORDS    = 320 * 240;
    localparam int SPACE    = 1 << ADDR_W;

    logic              i_clk;
    logic              i_n_reset;
    logic              i_drawing;
    logic              i_disp_req;
    logic [ADDR_W-1:0] i_disp_addr;
    logic              o_disp_gnt;
    logic              o_disp_rvalid;
    logic [DATA_W-1:0] o_disp_rdata;
    logic              i_wr_req;
    logic [ADDR_W-1:0] i_wr_addr;
    logic [DATA_W-1:0] i_wr_data;
    logic              o_wr_gnt;
    logic              o_mem_en;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [DATA_W-1:0] i_mem_rdata;
    logic              i_stall_clr;
    logic [15:0]       o_stall_cnt;

    fb_access_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MAX_WAIT   (MAX_WAIT),
        .RD_LATENCY (RD_LAT)
    ) dut (
        .i_clk         (i_clk),
        .i_n_reset     (i_n_reset),
        .i_drawing     (i_drawing),
        .i_disp_req    (i_disp_req),
        .i_disp_addr   (i_disp_addr),
        .o_disp_gnt    (o_disp_gnt),
        .o_disp_rvalid (o_disp_rvalid),
        .o_disp_rdata  (o_disp_rdata),
        .i_wr_req      (i_wr_req),
        .i_wr_addr     (i_wr_addr),
        .i_wr_data     (i_wr_data),
        .o_wr_gnt      (o_wr_gnt),
        .o_mem_en      (o_mem_en),
        .o_mem_we      (o_mem_we),
        .o_mem_addr    (o_mem_addr),
        .o_mem_wdata   (o_mem_wdata),
        .i_mem_rdata   (i_mem_rdata),
        .i_stall_clr   (i_stall_clr),
        .o_stall_cnt   (o_stall_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------- RAM environment (write-first, RD_LAT cycles) --------
    logic [DATA_W-1:0] ram [SPACE];
    logic [DATA_W-1:0] ram_pipe [RD_LAT];

    always @(posedge i_clk) begin
        if (o_mem_en && o_mem_we) ram[o_mem_addr] <= o_mem_wdata;
        if (o_mem_en && !o_mem_we) ram_pipe[0] <= ram[o_mem_addr];
        for (int i = 1; i < RD_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign i_mem_rdata = ram_pipe[RD_LAT-1];

    // ---------------- checking ---------------------------------------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model --------------------------------------
    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } rd_t;

    logic [DATA_W-1:0] shadow [SPACE];
    rd_t               rdq[$];
    int                cyc = 0;
    int                streak = 0;
    int                stall_m = 0;
    bit                m_en, m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata, m_rdata;
    bit                pend_wr;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_data;
    bit                obs_dg, obs_wg, obs_rv;

    task automatic model_clear();
        streak  = 0;
        stall_m = 0;
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_rdata = '0;
        pend_wr = 1'b0;
        rdq.delete();
    endtask

    // Runs once per cycle at the falling edge: checks everything the DUT
    // shows this cycle, then advances the model by this cycle's decisions.
    task automatic model_cycle();
        bit eg_d, eg_w, exp_rv, force_wr;
        obs_dg = o_disp_gnt;
        obs_wg = o_wr_gnt;
        obs_rv = o_disp_rvalid;
        if (!i_n_reset) begin
            check("rst_disp_gnt", 32'(o_disp_gnt), 32'd0);
            check("rst_wr_gnt",   32'(o_wr_gnt), 32'd0);
            check("rst_mem_en",   32'(o_mem_en), 32'd0);
            check("rst_mem_we",   32'(o_mem_we), 32'd0);
            check("rst_mem_addr", 32'(o_mem_addr), 32'd0);
            check("rst_mem_wdata",32'(o_mem_wdata), 32'd0);
            check("rst_rvalid",   32'(o_disp_rvalid), 32'd0);
            check("rst_rdata",    32'(o_disp_rdata), 32'd0);
            check("rst_stall",    32'(o_stall_cnt), 32'd0);
            model_clear();
            return;
        end

        // A write granted last cycle reaches the RAM at the coming edge
        // unless reset intervened, which the branch above already handled.
        if (pend_wr) begin
            shadow[pend_addr] = pend_data;
            pend_wr = 1'b0;
        end

        check("mem_en",    32'(o_mem_en), 32'(m_en));
        check("mem_we",    32'(o_mem_we), 32'(m_we));
        check("mem_addr",  32'(o_mem_addr), 32'(m_addr));
        check("mem_wdata", 32'(o_mem_wdata), 32'(m_wdata));

        exp_rv = (rdq.size() > 0) && (rdq[0].due == cyc);
        if (exp_rv) begin
            m_rdata = rdq[0].data;
            void'(rdq.pop_front());
        end
        check("rvalid", 32'(o_disp_rvalid), 32'(exp_rv));
        check("rdata",  32'(o_disp_rdata), 32'(m_rdata));
        check("stall",  32'(o_stall_cnt), 32'(stall_m));

        force_wr = i_wr_req && (streak >= MAX_WAIT);
        if (force_wr) begin
            eg_w = 1'b1;
            eg_d = 1'b0;
        end else if (i_drawing) begin
            eg_d = i_disp_req;
            eg_w = i_wr_req && !i_disp_req;
        end else begin
            eg_w = i_wr_req;
            eg_d = i_disp_req && !i_wr_req;
        end
        check("disp_gnt", 32'(o_disp_gnt), 32'(eg_d));
        check("wr_gnt",   32'(o_wr_gnt), 32'(eg_w));

        if (i_wr_req && !eg_w) begin
            if (streak < MAX_WAIT) streak++;
        end else begin
            streak = 0;
        end

        if (i_stall_clr) stall_m = 0;
        else if (i_drawing && i_disp_req && !eg_d && stall_m < 65535) stall_m++;

        m_en = eg_d || eg_w;
        m_we = eg_w;
        if (eg_w) begin
            m_addr    = i_wr_addr;
            m_wdata   = i_wr_data;
            pend_wr   = 1'b1;
            pend_addr = i_wr_addr;
            pend_data = i_wr_data;
        end else if (eg_d) begin
            m_addr = i_disp_addr;
            rdq.push_back('{due: cyc + 2 + RD_LAT, data: shadow[i_disp_addr]});
        end
    endtask

    task automatic step();
        @(negedge i_clk);
        model_cycle();
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    // Requesters: a pending request is held until granted; otherwise a new
    // one is raised with the given probability.
    task automatic drive(input int dpct, input int wpct, input int tog_pct, input int clr_pct);
        if (!i_disp_req || obs_dg) begin
            i_disp_req  = ($urandom_range(99) < dpct);
            i_disp_addr = ADDR_W'($urandom_range(512, WORDS - 1));
        end
        if (!i_wr_req || obs_wg) begin
            i_wr_req  = ($urandom_range(99) < wpct);
            i_wr_addr = ADDR_W'($urandom_range(512, WORDS - 1));
            i_wr_data = DATA_W'($urandom);
        end
        if ($urandom_range(99) < tog_pct) i_drawing = !i_drawing;
        i_stall_clr = ($urandom_range(99) < clr_pct);
    endtask

    int first_wr, wr_cnt, rv_early;

    initial begin
        for (int a = 0; a < SPACE; a++) begin
            ram[a]    = DATA_W'(a * 37 + (a >> 8));
            shadow[a] = ram[a];
        end
        ram[17'h00123]    = 8'h5A;
        shadow[17'h00123] = 8'h5A;
        for (int i = 0; i < RD_LAT; i++) ram_pipe[i] = '0;
        model_clear();

        i_n_reset   = 1'b1;
        i_drawing   = 1'b1;
        i_disp_req  = 1'b1;
        i_disp_addr = 17'h00400;
        i_wr_req    = 1'b1;
        i_wr_addr   = 17'h00500;
        i_wr_data   = 8'h11;
        i_stall_clr = 1'b0;
        #2 i_n_reset = 1'b0;

        // Reset held with both requests pending.
        repeat (3) step();
        i_n_reset = 1'b1;

        // Visible contention: 15 display grants, then one forced writer grant.
        first_wr = -1;
        wr_cnt   = 0;
        for (int i = 0; i < 48; i++) begin
            step();
            if (obs_wg) begin
                wr_cnt++;
                if (first_wr < 0) first_wr = i;
            end
            drive(100, 100, 0, 0);
        end
        check("vis_first_force", 32'(first_wr), 32'd15);
        check("vis_force_count", 32'(wr_cnt), 32'd3);
        check("vis_stall_cnt",   32'(o_stall_cnt), 32'd3);

        // Blanking contention: writer wins every cycle, no stall counted.
        i_drawing = 1'b0;
        wr_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (obs_wg) wr_cnt++;
            drive(100, 100, 0, 0);
        end
        check("blank_wr_count", 32'(wr_cnt), 32'd8);
        check("blank_stall",    32'(o_stall_cnt), 32'd3);
        drive(100, 0, 0, 0);
        step();
        check("blank_disp_after_drop", 32'(obs_dg), 32'd1);

        // Drain to idle.
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0);
            step();
        end
        drive(0, 0, 0, 0);

        // Read latency: grant at N, command at N+1, data at N+3.
        i_drawing   = 1'b1;
        i_disp_req  = 1'b1;
        i_disp_addr = 17'h00123;
        step();
        check("lat_gnt", 32'(obs_dg), 32'd1);
        i_disp_req = 1'b0;
        check("lat_cmd_en",   32'(o_mem_en), 32'd1);
        check("lat_cmd_we",   32'(o_mem_we), 32'd0);
        check("lat_cmd_addr", 32'(o_mem_addr), 32'h00123);
        step();
        step();
        check("lat_rvalid", 32'(o_disp_rvalid), 32'd1);
        check("lat_rdata",  32'(o_disp_rdata), 32'h5A);

        // Write then read the same address on consecutive grants.
        i_drawing = 1'b0;
        i_wr_req  = 1'b1;
        i_wr_addr = 17'h1F000;
        i_wr_data = 8'hA7;
        step();
        check("wtr_wr_gnt", 32'(obs_wg), 32'd1);
        i_wr_req    = 1'b0;
        i_disp_req  = 1'b1;
        i_disp_addr = 17'h1F000;
        step();
        check("wtr_rd_gnt", 32'(obs_dg), 32'd1);
        i_disp_req = 1'b0;
        step();
        step();
        check("wtr_rvalid", 32'(o_disp_rvalid), 32'd1);
        check("wtr_rdata",  32'(o_disp_rdata), 32'hA7);

        // Reset one cycle after a display grant, with writer starvation built up.
        i_drawing = 1'b1;
        drive(100, 100, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            drive(100, 100, 0, 0);
        end
        check("mid_rst_pre_gnt", 32'(obs_dg), 32'd1);
        i_n_reset = 1'b0;
        repeat (3) step();
        i_n_reset = 1'b1;
        first_wr = -1;
        rv_early = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i < 3 && obs_rv) rv_early++;
            if (obs_wg && first_wr < 0) first_wr = i;
            drive(100, 100, 0, 0);
        end
        check("mid_rst_no_rvalid",   32'(rv_early), 32'd0);
        check("mid_rst_first_force", 32'(first_wr), 32'd15);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            step();
            drive(60, 50, 3, 2);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            drive(0, 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fb_access_arbiter.md
Name: fb_access_arbiter

Overview:
- Shares one single-port framebuffer RAM between two requesters:
  - the display fetch path, which turns pixel coordinates into RAM reads;
  - the draw writer, which writes shape/pixel commands into RAM.
- Sits between the VGA timing core (uses its o_drawing flag) and the framebuffer RAM.
- Display has priority during the visible region; the writer has priority during blanking.
- A starvation counter guarantees the writer forward progress.

Parameters:
- ADDR_W, 17, framebuffer word-address width (320x240 = 76800 words).
- DATA_W, 8, pixel word width.
- MAX_WAIT, 15, consecutive denied writer cycles before a forced writer grant (1..255).
- RD_LATENCY, 1, RAM read latency in cycles from the registered command (1..4).

Ports:
- i_clk  in  1  system clock; all logic is on the rising edge.
- i_n_reset  in  1  asynchronous, active-low reset.
- i_drawing  in  1  high in the visible region (from VGA timing core), low in blanking.
- i_disp_req  in  1  display read request; held until granted.
- i_disp_addr  in  ADDR_W  display read address.
- o_disp_gnt  out  1  combinational; request accepted this cycle.
- o_disp_rvalid  out  1  registered; read data valid.
- o_disp_rdata  out  DATA_W  registered read data.
- i_wr_req  in  1  write request; held until granted.
- i_wr_addr  in  ADDR_W  write address.
- i_wr_data  in  DATA_W  write data.
- o_wr_gnt  out  1  combinational; write accepted this cycle.
- o_mem_en  out  1  registered RAM enable.
- o_mem_we  out  1  registered RAM write enable.
- o_mem_addr  out  ADDR_W  registered RAM address.
- o_mem_wdata  out  DATA_W  registered RAM write data.
- i_mem_rdata  in  DATA_W  RAM read data.
- i_stall_clr  in  1  synchronous clear of o_stall_cnt.
- o_stall_cnt  out  16  saturating count of cycles with i_drawing=1, i_disp_req=1, o_disp_gnt=0.

Behaviour:
- Reset (async, i_n_reset=0) sets all registers and outputs to 0:
  - mem command, rvalid pipeline, o_disp_rdata, wait_cnt, o_stall_cnt, FSM state (NORMAL).
  - Grants are also 0 while in reset.
- Handshake:
  - A request is transferred in the cycle where req && gnt.
  - The requester must hold req, addr and data stable until then.
  - At most one grant per cycle; grants never assert without the matching req.
- Grant decision, combinational, evaluated per cycle in priority order:
  1. FSM state FORCE_WR and i_wr_req: writer granted, display denied.
  2. i_drawing=1: display granted if i_disp_req; writer granted only if !i_disp_req.
  3. i_drawing=0: writer granted if i_wr_req; display granted only if !i_wr_req.
- FSM (2 states):
  - NORMAL -> FORCE_WR when wait_cnt reaches MAX_WAIT with i_wr_req high.
  - FORCE_WR -> NORMAL after the writer grant cycle, or if i_wr_req drops.
  - FORCE_WR lasts exactly one grant.
- wait_cnt (8-bit):
  - Cleared when o_wr_gnt=1 or i_wr_req=0.
  - Otherwise increments, saturating at MAX_WAIT.
- Command register: on a grant in cycle N, at edge N+1 the mem outputs take the following values:
  - o_mem_en=1.
  - o_mem_we=1 for the writer, 0 for display.
  - o_mem_addr and o_mem_wdata from the granted requester; wdata holds its previous value for reads.
  - With no grant, o_mem_en=0 and o_mem_we=0; addr and wdata hold.
- Read return:
  - A display grant at cycle N enters a RD_LATENCY-deep valid shift pipe.
  - i_mem_rdata is captured into o_disp_rdata; o_disp_rvalid=1 for one cycle, first visible at cycle N+2+RD_LATENCY (N+3 at default).
  - Back-to-back grants give back-to-back rvalid, in order.
- Write-then-read to the same address in consecutive cycles returns the new data; the RAM is write-first and ordering is preserved by the single command stream.
- i_drawing toggling with both requests pending takes effect in the same cycle; there is no hysteresis.
- o_stall_cnt:
  - Increments on each display-stall cycle, saturating at 16'hFFFF.
  - i_stall_clr wins over an increment in the same cycle.
- Reset mid-transfer drops in-flight reads; no rvalid is emitted after reset deassertion for pre-reset grants.

Decomposition:
- Package vga_pkg:
  - FB_ADDR_W and FB_DATA_W constants, shared with the display fetch and draw writer.
  - Typedef arb_state_t {NORMAL, FORCE_WR}.
- One sub-module, fb_rd_valid_pipe: parameterised RD_LATENCY shift register with async clear, producing the rvalid strobe and the rdata capture enable.

Test Plan:
- Reset: hold i_n_reset=0 with both reqs high. Expect all outputs 0, no grants; the first grant appears in the cycle after release.
- Visible contention, MAX_WAIT=15, i_drawing=1, both reqs held continuously:
  - display granted 15 cycles;
  - writer force-granted on the 16th cycle with o_disp_gnt=0;
  - pattern repeats;
  - o_stall_cnt increments by 1 per forced cycle.
- Blanking contention, i_drawing=0, both reqs:
  - writer granted every cycle;
  - display granted only after i_wr_req drops;
  - o_stall_cnt unchanged.
- Read latency: display read addr 0x00123 granted at cycle 10 with the RAM model returning 0x5A. Expect o_mem_en=1, we=0, addr=0x00123 at cycle 11; o_disp_rvalid=1 and rdata=0x5A at cycle 13.
- Write-then-read: write 0xA7 to 0x1F000 then read 0x1F000 on consecutive grants. Expect rdata=0xA7.
- Async reset asserted one cycle after a display grant: no rvalid after release; wait_cnt and FSM back to 0 and NORMAL.
